cam_capture_ctrl: RTL
=====================

# cam_capture_ctrl

Frame-capture sequencer for the OV7670 pixel path. Arms capture on request, aligns to the camera's vertical sync, gates the pixel writer (`cap_en`) for exactly one frame (single-shot) or for successive frames (continuous), and counts pixels and lines. Optionally checks that each frame has the expected geometry. Sits between the host/control logic and the camera-to-framebuffer writer, in the `pclk` domain.

## Interface
- `H_PIX`, 160, pixels per line expected (QQVGA)
- `V_LINES`, 120, lines per frame expected
- `AW`, 15, framebuffer address width; width of `px_total`
- `CW`, 9, width of the column and line counters
- `pclk` input 1: single clock; all logic on rising edge
- `rst` input 1: synchronous, active-low reset (low on a `pclk` edge resets)
- `start` input 1: capture request, sampled in IDLE only
- `cont` input 1: continuous mode, sampled with `start`
- `stop` input 1: stop request
- `vsync` input 1: camera vsync; high = vertical blanking
- `href` input 1: camera line-valid
- `px_stb` input 1: one-cycle pulse per pixel stored by the writer
- `cap_en` output 1: enables the pixel writer
- `busy` output 1: state ≠ IDLE
- `frame_done` output 1: one-cycle pulse on a good frame end
- `frame_err` output 1: sticky geometry error; cleared by the next accepted `start`
- `frame_cnt` output 8: completed good frames; wraps 255→0
- `px_total` output AW: pixels in the current or last frame; saturates at 2^AW−1

## Operation
- Registered `vsync_q` and `href_q`:
  - Frame start (FS) = `vsync_q`=1 & `vsync`=0.
  - Frame end (FE) = `vsync_q`=0 & `vsync`=1.
  - Line end (LE) = `href_q`=1 & `href`=0.
- States: IDLE, ARM, SYNC, CAPTURE, DONE, ERR.
- IDLE:
  - `start`=1 & `stop`=0 → ARM.
  - Latches `cont`, clears `frame_err`, `px_total`, col, line.
  - `start` & `stop` together: stop wins, stay IDLE.
- ARM: wait for `vsync`=1 → SYNC. This guarantees capture never begins mid-frame.
- SYNC: on FS → CAPTURE; col, line, `px_total` cleared.
- CAPTURE:
  - `px_stb` increments col and `px_total`.
  - LE increments line and clears col.
  - FE → DONE, or → ERR if the error flag is set.
- DONE:
  - One cycle; `frame_done`=1; `frame_cnt`+1.
  - Then → SYNC if the latched `cont`=1 and no stop pending; otherwise → IDLE.
- ERR: one cycle; sets `frame_err` → IDLE. `frame_cnt` is unchanged; `frame_done` stays 0.
- `stop`:
  - In ARM/SYNC: → IDLE next cycle.
  - In CAPTURE: sets `stop_pend`; the frame completes, then DONE/ERR → IDLE.
- Counter rules:
  - col and line saturate at 2^CW−1.
  - `px_stb` outside CAPTURE is ignored.
  - `px_stb` and LE in the same cycle: the pixel counts in the ending line's total before col clears.

## Timing
- Reset values:
  - State IDLE.
  - `cap_en`, `busy`, `frame_done`, `frame_err` all 0.
  - `frame_cnt`, `px_total`, col, line all 0.
  - `vsync_q`=1, `href_q`=0.
- `cap_en` is registered; it equals (state==CAPTURE).
  - Rises on the cycle after FS is sampled.
  - Falls on the cycle after FE is sampled.
- `busy` rises 1 cycle after an accepted `start`.
- `frame_done` asserts 1 cycle after FE, for 1 cycle.
- Continuous mode: DONE → SYNC. Because `vsync` is high, the next FS is caught with no frame skipped.
- Reset mid-CAPTURE: all state returns to reset values at that edge; `cap_en` is 0 the next cycle.

## Configuration
- `CAP_SIZE_CHECK_EN` defined:
  - At each LE, col ≠ `H_PIX` sets the error flag.
  - At FE, line ≠ `V_LINES` sets the error flag.
  - `px_stb` while `href`=0 in CAPTURE sets the error flag.
  - The flag is cleared on FS; FE with the flag set → ERR.
- Undefined: no checks, ERR is unreachable, `frame_err` is tied 0, and every FE in CAPTURE → DONE.

## Test plan
- Reset during CAPTURE: `rst`=0 for one edge → next cycle `cap_en`=0, `busy`=0, `frame_cnt`=0, `px_total`=0.
- Single-shot, good frame:
  - Stimulus: `start` (`cont`=0) while `vsync`=0, then vsync high, then 120 lines of 160 `px_stb`.
  - Response: `cap_en` only between FS+1 and FE+1; `px_total`=19200; one `frame_done`; `frame_cnt`=1; back to IDLE.
- Continuous, three frames, then `stop` mid-frame 3 → `frame_cnt`=3; IDLE after frame 3 FE; `cap_en` never asserted for frame 4.
- Short line (`CAP_SIZE_CHECK_EN`): one line of 159 pixels → at FE `frame_err`=1, no `frame_done`, `frame_cnt` unchanged. A new `start` clears `frame_err`.
- `start` and `stop` in the same IDLE cycle → stays IDLE, `busy`=0.
- Counter limits:
  - 256 good frames in continuous mode → `frame_cnt` wraps to 0.
  - With `AW`=8, a 300-pixel frame → `px_total`=255.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: frame-capture sequencer for the OV7670 pixel path (pclk domain).
// Arms on a capture request and waits for vertical blanking. It gates the pixel
// writer for one frame, or for successive frames in continuous mode, and counts
// pixels and lines.
// Optional feature macro: CAP_SIZE_CHECK_EN enables frame-geometry checking
// (line length, line count, stray pixel strobes) and the ERR path.
module cam_capture_ctrl #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int AW      = 15,
  parameter int CW      = 9
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          start,
  input  logic          cont,
  input  logic          stop,
  input  logic          vsync,
  input  logic          href,
  input  logic          px_stb,
  output logic          cap_en,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err,
  output logic [7:0]    frame_cnt,
  output logic [AW-1:0] px_total
);

`ifdef CAP_SIZE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SYNC, S_CAPTURE, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          vsync_q, href_q;
  logic          cont_q, cont_d;
  logic          stop_pend_q, stop_pend_d;
  logic          err_flag_q, err_flag_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [AW-1:0] px_total_q, px_total_d;
  logic [CW-1:0] col_q, col_d, line_q, line_d;
  logic          cap_en_q, busy_q, frame_done_q;

  // Edge events on the camera sync lines, relative to the previous cycle.
  logic fs, fe, le;
  assign fs = vsync_q & ~vsync;
  assign fe = ~vsync_q & vsync;
  assign le = href_q & ~href;

  // A start is taken only in IDLE, and a simultaneous stop cancels it.
  logic start_ok;
  assign start_ok = (state_q == S_IDLE) && start && !stop;

  // Saturating increments and the same-cycle view of col/line.
  logic [CW-1:0] col_inc, col_eff, line_inc, line_eff;
  logic [AW-1:0] px_inc;
  assign col_inc  = (col_q == '1) ? col_q : col_q + CW'(1);
  assign col_eff  = px_stb ? col_inc : col_q;
  assign line_inc = (line_q == '1) ? line_q : line_q + CW'(1);
  assign line_eff = le ? line_inc : line_q;
  assign px_inc   = (px_total_q == '1) ? px_total_q : px_total_q + AW'(1);

  // Pixel/line counters and the per-frame geometry error flag.
  always_comb begin
    col_d      = col_q;
    line_d     = line_q;
    px_total_d = px_total_q;
    err_flag_d = err_flag_q;
    if (start_ok) begin
      col_d      = '0;
      line_d     = '0;
      px_total_d = '0;
    end else if (state_q == S_SYNC && !stop && fs) begin
      col_d      = '0;
      line_d     = '0;
      px_total_d = '0;
      err_flag_d = 1'b0;
    end else if (state_q == S_CAPTURE) begin
      if (px_stb) px_total_d = px_inc;
      if (px_stb && !href) err_flag_d = 1'b1;
      // A pixel strobed on the line-end cycle still belongs to the ending line.
      if (le) begin
        if (col_eff != CW'(H_PIX)) err_flag_d = 1'b1;
        line_d = line_inc;
        col_d  = '0;
      end else begin
        col_d = col_eff;
      end
      if (fe && line_eff != CW'(V_LINES)) err_flag_d = 1'b1;
    end
  end

  // Sequencer next-state: arm, align to blanking, capture, then finish or repeat.
  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d     = S_ARM;
          cont_d      = cont;
          stop_pend_d = 1'b0;
        end
      end
      S_ARM: begin
        if (stop)       state_d = S_IDLE;
        else if (vsync) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (stop)    state_d = S_IDLE;
        else if (fs) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (stop) stop_pend_d = 1'b1;
        if (fe)   state_d = (CHECK_EN && err_flag_d) ? S_ERR : S_DONE;
      end
      S_DONE: begin
        state_d     = (cont_q && !stop_pend_q && !stop) ? S_SYNC : S_IDLE;
        stop_pend_d = 1'b0;
      end
      S_ERR: begin
        state_d     = S_IDLE;
        stop_pend_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame counter and sticky error follow the transitions into DONE/ERR.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    frame_err_d = frame_err_q;
    if (state_q == S_CAPTURE && state_d == S_DONE) frame_cnt_d = frame_cnt_q + 8'd1;
    if (start_ok)          frame_err_d = 1'b0;
    if (state_d == S_ERR)  frame_err_d = 1'b1;
  end

  // State and registered outputs; outputs mirror the state being entered.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      vsync_q      <= 1'b1;
      href_q       <= 1'b0;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      err_flag_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
      px_total_q   <= '0;
      col_q        <= '0;
      line_q       <= '0;
      cap_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      href_q       <= href;
      cont_q       <= cont_d;
      stop_pend_q  <= stop_pend_d;
      err_flag_q   <= err_flag_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
      px_total_q   <= px_total_d;
      col_q        <= col_d;
      line_q       <= line_d;
      cap_en_q     <= (state_d == S_CAPTURE);
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_DONE);
    end
  end

  assign cap_en     = cap_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign px_total   = px_total_q;

endmodule
